// File: rtl/sad_search.sv
// Sum-of-absolute-differences block-matching engine: streams NUM_CAND candidates of
// BLOCK_LEN pairs, reports each SAD and tracks the best. Optional pruning: SAD_EARLY_TERM_EN.
module sad_search #(
    parameter  int DATA_W    = 8,
    parameter  int BLOCK_LEN = 256,
    parameter  int NUM_CAND  = 16,
    localparam int SUM_W     = DATA_W + $clog2(BLOCK_LEN),
    localparam int IDX_W     = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] dta_i,
    input  logic [DATA_W-1:0] dtb_i,
    output logic              sad_valid_o,
    output logic [SUM_W-1:0]  sad_o,
    output logic [IDX_W-1:0]  sad_idx_o,
    output logic              best_valid_o,
    output logic [SUM_W-1:0]  best_sad_o,
    output logic [IDX_W-1:0]  best_idx_o,
    output logic              busy_o
);

    // state | meaning
    // IDLE  | waiting for start_i, results of last search held
    // ACCUM | accepting pairs of the current candidate
    // DRAIN | last pair taken, waiting for the pipeline to report the SAD
    // DONE  | search finished, publish best_valid_o and drop busy_o
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    localparam int CNT_W = $clog2(BLOCK_LEN);
    localparam logic [CNT_W-1:0] PAIR_LAST = CNT_W'(BLOCK_LEN - 1);
    localparam logic [IDX_W-1:0] CAND_LAST = IDX_W'(NUM_CAND - 1);

    state_t            state_q;
    logic              arm_q;
    logic [CNT_W-1:0]  pair_cnt_q;
    logic [IDX_W-1:0]  cand_q;

    logic              s1_vld_q;
    logic              s1_last_q;
    logic [DATA_W-1:0] s1_diff_q;
    logic              s2_last_q;
    logic [SUM_W-1:0]  acc_q;

    logic              accept;
    logic              prune_now;
    logic              take_best;
    logic [DATA_W-1:0] abs_diff;

    assign in_ready_o = (state_q == ACCUM);
    assign accept     = in_valid_i && in_ready_o;
    assign abs_diff   = (dta_i > dtb_i) ? (dta_i - dtb_i) : (dtb_i - dta_i);

`ifdef SAD_EARLY_TERM_EN
    logic pruned_q;
    // Candidate 0 seeds best_sad_o, so it can never be pruned.
    assign prune_now = (cand_q != '0) && (pruned_q || (acc_q >= best_sad_o));
`else
    assign prune_now = 1'b0;
`endif

    assign take_best = s2_last_q && !prune_now && ((cand_q == '0) || (acc_q < best_sad_o));

    // arm_q stays low through the reset-release edge so a start there is ignored.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            arm_q        <= 1'b0;
            pair_cnt_q   <= '0;
            cand_q       <= '0;
            busy_o       <= 1'b0;
            best_valid_o <= 1'b0;
            best_sad_o   <= '0;
            best_idx_o   <= '0;
        end else begin
            arm_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (start_i && arm_q) begin
                        state_q      <= ACCUM;
                        pair_cnt_q   <= PAIR_LAST;
                        cand_q       <= '0;
                        busy_o       <= 1'b1;
                        best_valid_o <= 1'b0;
                        best_sad_o   <= '0;
                        best_idx_o   <= '0;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (pair_cnt_q == '0) state_q <= DRAIN;
                        else                  pair_cnt_q <= pair_cnt_q - 1'b1;
                    end
                end
                DRAIN: begin
                    if (s2_last_q) begin
                        if (cand_q == CAND_LAST) begin
                            state_q <= DONE;
                        end else begin
                            state_q    <= ACCUM;
                            cand_q     <= cand_q + 1'b1;
                            pair_cnt_q <= PAIR_LAST;
                        end
                    end
                end
                DONE: begin
                    state_q      <= IDLE;
                    busy_o       <= 1'b0;
                    best_valid_o <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
            if (take_best) begin
                best_sad_o <= acc_q;
                best_idx_o <= cand_q;
            end
        end
    end

    // Two-stage datapath: |a-b| register, then accumulate; report and clear together.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            s1_vld_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_diff_q   <= '0;
            s2_last_q   <= 1'b0;
            acc_q       <= '0;
            sad_valid_o <= 1'b0;
            sad_o       <= '0;
            sad_idx_o   <= '0;
`ifdef SAD_EARLY_TERM_EN
            pruned_q    <= 1'b0;
`endif
        end else begin
            s1_vld_q    <= accept;
            s1_last_q   <= accept && (pair_cnt_q == '0);
            s1_diff_q   <= accept ? abs_diff : '0;
            s2_last_q   <= s1_last_q;
            sad_valid_o <= s2_last_q;
            if (s2_last_q) begin
                sad_o     <= prune_now ? {SUM_W{1'b1}} : acc_q;
                sad_idx_o <= cand_q;
                acc_q     <= '0;
`ifdef SAD_EARLY_TERM_EN
                pruned_q  <= 1'b0;
`endif
            end else begin
`ifdef SAD_EARLY_TERM_EN
                if (s1_vld_q && !pruned_q) acc_q <= acc_q + SUM_W'(s1_diff_q);
                if (cand_q != '0 && acc_q >= best_sad_o && state_q != IDLE) pruned_q <= 1'b1;
`else
                if (s1_vld_q) acc_q <= acc_q + SUM_W'(s1_diff_q);
`endif
            end
        end
    end

endmodule
